// File: rtl/incdec_pkg.sv
// Shared op encodings and sequencer states for the incdec_seq pointer unit.
package incdec_pkg;

  localparam logic [1:0] OP_HOLD = 2'b00;
  localparam logic [1:0] OP_INC  = 2'b01;
  localparam logic [1:0] OP_DEC  = 2'b10;
  localparam logic [1:0] OP_LOAD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/incdec_step.sv
// Combinational WIDTH-bit +1/-1 with carry (wrap on increment) or borrow (wrap on decrement).
module incdec_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic             dec_i,
  output logic [WIDTH-1:0] y_o,
  output logic             c_o
);

  always_comb begin
    if (dec_i) begin
      y_o = a_i - WIDTH'(1);
      c_o = (a_i == '0);
    end else begin
      y_o = a_i + WIDTH'(1);
      c_o = &a_i;
    end
  end

endmodule

// File: rtl/incdec_seq.sv
// Multi-channel pointer unit with single ops and a stallable block-step sequencer.
// Build option: INCDEC_INV_OUT_EN drives AddrBus inverted (legacy negative-polarity bus).
module incdec_seq
  import incdec_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NCH   = 4,
  parameter int LENW  = 8,
  localparam int CHW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             CLK,
  input  logic             nRESET,
  input  logic             op_valid,
  input  logic [1:0]       op,
  input  logic [CHW-1:0]   ch,
  input  logic [WIDTH-1:0] din,
  input  logic             blk_start,
  input  logic             blk_dir,
  input  logic [LENW-1:0]  blk_len,
  input  logic             stall,
  output logic [WIDTH-1:0] addr,
  output logic [WIDTH-1:0] AddrBus,
  output logic             cout,
  output logic             busy,
  output logic             done,
  output logic             ovr
);

  state_e          state_q;
  logic [CHW-1:0]  bch_q;
  logic            bdir_q;
  logic [LENW-1:0] rem_q;
  logic            cout_q, busy_q, done_q, ovr_q;

  logic [WIDTH-1:0] ptr [NCH];
  logic [WIDTH-1:0] op_src, op_res, op_val, blk_src, blk_res, bus_sel;
  logic             op_c, op_cout, blk_c;
  logic             blk_accept, blk_step, op_drop, op_take;

  // The block latches the requesting channel, so a same-cycle op always collides with it.
  assign blk_accept = (state_q == ST_IDLE) && blk_start;
  assign blk_step   = (state_q == ST_RUN) && !stall;
  assign op_drop    = op_valid && (blk_accept || ((state_q == ST_RUN) && (ch == bch_q)));
  assign op_take    = op_valid && !op_drop;

  assign op_src  = ptr[ch];
  assign blk_src = ptr[bch_q];

  incdec_step #(.WIDTH(WIDTH)) u_step_op (
    .a_i   (op_src),
    .dec_i (op == OP_DEC),
    .y_o   (op_res),
    .c_o   (op_c)
  );

  incdec_step #(.WIDTH(WIDTH)) u_step_blk (
    .a_i   (blk_src),
    .dec_i (bdir_q),
    .y_o   (blk_res),
    .c_o   (blk_c)
  );

  always_comb begin
    case (op)
      OP_INC, OP_DEC: begin op_val = op_res; op_cout = op_c; end
      OP_LOAD:        begin op_val = din;    op_cout = 1'b0; end
      default:        begin op_val = op_src; op_cout = 1'b0; end
    endcase
  end

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    logic [WIDTH-1:0] ptr_q, ptr_d;

    always_comb begin
      ptr_d = ptr_q;
      if (op_take && (ch == CHW'(gi)))
        ptr_d = op_val;
      if (blk_step && (bch_q == CHW'(gi)))
        ptr_d = blk_res;
    end

    always_ff @(posedge CLK or negedge nRESET) begin
      if (!nRESET) ptr_q <= '0;
      else         ptr_q <= ptr_d;
    end

    assign ptr[gi] = ptr_q;
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q <= ST_IDLE;
      bch_q   <= '0;
      bdir_q  <= 1'b0;
      rem_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      ovr_q  <= op_drop;
      done_q <= 1'b0;
      // A block step owns cout when it coincides with a single op.
      if (blk_step)     cout_q <= blk_c;
      else if (op_take) cout_q <= op_cout;
      case (state_q)
        ST_IDLE: begin
          if (blk_start) begin
            bch_q  <= ch;
            bdir_q <= blk_dir;
            rem_q  <= blk_len;
            busy_q <= 1'b1;
            if (blk_len == '0) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (!stall) begin
            rem_q <= rem_q - LENW'(1);
            if (rem_q == LENW'(1)) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus_sel = (state_q == ST_RUN) ? blk_src : op_src;
  assign addr    = op_src;
`ifdef INCDEC_INV_OUT_EN
  assign AddrBus = ~bus_sel;
`else
  assign AddrBus = bus_sel;
`endif
  assign cout = cout_q;
  assign busy = busy_q;
  assign done = done_q;
  assign ovr  = ovr_q;

endmodule

// File: tb/tb_incdec_seq.sv
// Self-checking bench for incdec_seq: vector table, block-run sequences, randomized run vs. reference model.
module tb_incdec_seq;
  localparam int WIDTH = 16;
  localparam int NCH   = 4;
  localparam int LENW  = 8;
  localparam int unsigned MASK = 32'h0000_FFFF;

  logic        CLK = 1'b0, nRESET = 1'b0;
  logic        op_valid = 1'b0, blk_start = 1'b0, blk_dir = 1'b0, stall = 1'b0;
  logic [1:0]  op = 2'd0, ch = 2'd0;
  logic [15:0] din = 16'd0;
  logic [7:0]  blk_len = 8'd0;
  logic [15:0] addr, AddrBus;
  logic        cout, busy, done, ovr;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  incdec_seq #(.WIDTH(WIDTH), .NCH(NCH), .LENW(LENW)) dut (
    .CLK(CLK), .nRESET(nRESET), .op_valid(op_valid), .op(op), .ch(ch), .din(din),
    .blk_start(blk_start), .blk_dir(blk_dir), .blk_len(blk_len), .stall(stall),
    .addr(addr), .AddrBus(AddrBus), .cout(cout), .busy(busy), .done(done), .ovr(ovr)
  );

  // Reference model: per-channel integers, a mode number and a remaining-step count.
  int unsigned m_ptr [NCH];
  int          m_mode;   // 0 idle, 1 running, 2 finishing
  int          m_bch, m_rem;
  bit          m_dir, m_cout, m_ovr;

  function automatic int unsigned bus_view(input int unsigned v);
`ifdef INCDEC_INV_OUT_EN
    return (~v) & MASK;
`else
    return v & MASK;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    foreach (m_ptr[i]) m_ptr[i] = 0;
    m_mode = 0; m_bch = 0; m_rem = 0; m_dir = 0; m_cout = 0; m_ovr = 0;
  endtask

  task automatic model_edge();
    int nmode;
    bit accept, bstep, drop;
    int c;
    nmode  = m_mode;
    c      = int'(ch);
    accept = (m_mode == 0) && blk_start;
    bstep  = (m_mode == 1) && !stall;
    drop   = op_valid && (accept || (m_mode == 1 && c == m_bch));
    if (op_valid && !drop) begin
      case (op)
        2'd1: begin m_cout = (m_ptr[c] == MASK); m_ptr[c] = (m_ptr[c] + 1) & MASK; end
        2'd2: begin m_cout = (m_ptr[c] == 0);    m_ptr[c] = (m_ptr[c] - 1) & MASK; end
        2'd3: begin m_cout = 0; m_ptr[c] = din; end
        default: m_cout = 0;
      endcase
    end
    if (bstep) begin
      if (m_dir) begin m_cout = (m_ptr[m_bch] == 0);    m_ptr[m_bch] = (m_ptr[m_bch] - 1) & MASK; end
      else       begin m_cout = (m_ptr[m_bch] == MASK); m_ptr[m_bch] = (m_ptr[m_bch] + 1) & MASK; end
      m_rem--;
      if (m_rem == 0) nmode = 2;
    end
    if (m_mode == 2) nmode = 0;
    if (accept) begin
      m_bch = c; m_dir = blk_dir; m_rem = int'(blk_len);
      nmode = (blk_len == 0) ? 2 : 1;
    end
    m_ovr  = drop;
    m_mode = nmode;
  endtask

  task automatic tick();
    model_edge();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_model(input string tag);
    int unsigned exp_bus;
    exp_bus = bus_view((m_mode == 1) ? m_ptr[m_bch] : m_ptr[int'(ch)]);
    check({tag, "_addr"}, addr, m_ptr[int'(ch)]);
    check({tag, "_bus"},  AddrBus, exp_bus);
    check({tag, "_cout"}, cout, m_cout);
    check({tag, "_busy"}, busy, m_mode != 0);
    check({tag, "_done"}, done, m_mode == 2);
    check({tag, "_ovr"},  ovr, m_ovr);
  endtask

  task automatic load(input logic [1:0] c, input logic [15:0] v);
    op_valid = 1; op = 2'd3; ch = c; din = v;
    tick();
    op_valid = 0;
  endtask

  // Runs an increment block on ch2 (preloaded 0x8000), stalling stall_n cycles before step stall_at.
  task automatic block_run(input int len, input int stall_at, input int stall_n, input string tag);
    int steps = 0, stalls = 0, busy_cyc = 0, done_cnt = 0, done_at = -1;
    op_valid = 0; ch = 2'd2; blk_dir = 0; blk_len = 8'(len); blk_start = 1;
    tick();
    blk_start = 0;
    for (int cyc = 0; cyc < 40 && busy === 1'b1; cyc++) begin
      stall = (steps == stall_at) && (stalls < stall_n);
      #1;
      busy_cyc++;
      if (done === 1'b1) begin
        done_cnt++;
        done_at = busy_cyc;
      end else begin
        check({tag, "_bus"}, AddrBus, bus_view(32'h8000 + steps));
        if (stall) stalls++;
        else       steps++;
      end
      tick();
    end
    stall = 0;
    #1;
    check({tag, "_busy_cycles"}, busy_cyc, len + 1 + stall_n);
    check({tag, "_done_count"}, done_cnt, 1);
    check({tag, "_done_last"}, done_at, len + 1 + stall_n);
    check({tag, "_ptr"}, addr, 32'h8000 + len);
    check({tag, "_idle"}, busy, 0);
    $display("block %s len=%0d stall=%0d busy_cycles=%0d ptr=%0h", tag, len, stall_n, busy_cyc, addr);
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [1:0]  ch;
    logic [15:0] din;
    logic [15:0] exp_addr;
    logic        exp_cout;
  } vec_t;

  vec_t vecs [12];

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{2'd3, 2'd1, 16'h1234, 16'h1234, 1'b0};
    vecs[1]  = '{2'd1, 2'd1, 16'h0000, 16'h1235, 1'b0};
    vecs[2]  = '{2'd3, 2'd0, 16'hFFFF, 16'hFFFF, 1'b0};
    vecs[3]  = '{2'd1, 2'd0, 16'h0000, 16'h0000, 1'b1};
    vecs[4]  = '{2'd2, 2'd0, 16'h0000, 16'hFFFF, 1'b1};
    vecs[5]  = '{2'd2, 2'd0, 16'h0000, 16'hFFFE, 1'b0};
    vecs[6]  = '{2'd0, 2'd0, 16'h0000, 16'hFFFE, 1'b0};
    vecs[7]  = '{2'd3, 2'd3, 16'h0001, 16'h0001, 1'b0};
    vecs[8]  = '{2'd2, 2'd3, 16'h0000, 16'h0000, 1'b0};
    vecs[9]  = '{2'd2, 2'd3, 16'h0000, 16'hFFFF, 1'b1};
    vecs[10] = '{2'd0, 2'd3, 16'h0000, 16'hFFFF, 1'b0};
    vecs[11] = '{2'd3, 2'd2, 16'h8000, 16'h8000, 1'b0};

    model_reset();
    nRESET = 0;
    repeat (2) @(posedge CLK);
    #1;
    for (int i = 0; i < NCH; i++) begin
      ch = 2'(i);
      #1;
      check("reset_addr", addr, 0);
      check("reset_bus", AddrBus, bus_view(0));
    end
    check("reset_cout", cout, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_ovr", ovr, 0);
    nRESET = 1;
    @(posedge CLK);
    #1;

    foreach (vecs[i]) begin
      op_valid = 1; op = vecs[i].op; ch = vecs[i].ch; din = vecs[i].din;
      tick();
      op_valid = 0;
      #1;
      check("vec_addr", addr, vecs[i].exp_addr);
      check("vec_cout", cout, vecs[i].exp_cout);
      check("vec_ovr", ovr, 0);
      $display("vec %0d op=%0d ch=%0d addr=%0h cout=%0b", i, vecs[i].op, vecs[i].ch, addr, cout);
    end

    ch = 2'd1;
    #1;
`ifdef INCDEC_INV_OUT_EN
    check("bus_polarity", AddrBus, 16'hEDCA);
`else
    check("bus_polarity", AddrBus, 16'h1235);
`endif

    block_run(3, -1, 0, "blk3");
    load(2'd2, 16'h8000);
    block_run(3, 1, 2, "blk3_stall");
    load(2'd2, 16'h8000);
    block_run(0, -1, 0, "blk0");

    // Ops during a run: same channel is dropped, another channel proceeds.
    load(2'd2, 16'h8000);
    load(2'd3, 16'h0010);
    ch = 2'd2; blk_dir = 0; blk_len = 8'd3; blk_start = 1;
    tick();
    blk_start = 0;
    op_valid = 1; op = 2'd1; ch = 2'd2;
    tick();
    op_valid = 0;
    #1;
    check("run_same_ch_ovr", ovr, 1);
    op_valid = 1; op = 2'd1; ch = 2'd3;
    tick();
    op_valid = 0;
    #1;
    check("run_other_ch_ovr", ovr, 0);
    check("run_other_ch_addr", addr, 16'h0011);
    check("run_bus_from_block", AddrBus, bus_view(32'h8002));
    tick();
    check("run_done", done, 1);
    tick();
    ch = 2'd2;
    #1;
    check("run_ptr_unaffected", addr, 16'h8003);
    $display("concurrent ops ch2=%0h", addr);

    // Block start and op on the same channel in the same cycle.
    ch = 2'd1; blk_dir = 1; blk_len = 8'd2; blk_start = 1;
    op_valid = 1; op = 2'd3; din = 16'h0000;
    tick();
    blk_start = 0; op_valid = 0;
    #1;
    check("start_collide_ovr", ovr, 1);
    tick(); tick(); tick();
    #1;
    check("start_collide_ptr", addr, 16'h1233);
    check("start_collide_cout", cout, 0);
    $display("collide ch1=%0h", addr);

    // Asynchronous reset in the middle of a run.
    ch = 2'd2; blk_dir = 0; blk_len = 8'd5; blk_start = 1;
    tick();
    blk_start = 0;
    tick(); tick();
    nRESET = 0;
    #1;
    model_reset();
    check("abort_busy", busy, 0);
    check("abort_addr", addr, 0);
    check("abort_bus", AddrBus, bus_view(0));
    @(posedge CLK);
    #1;
    nRESET = 1;
    begin
      int seen_done = 0;
      for (int i = 0; i < 8; i++) begin
        tick();
        if (done === 1'b1) seen_done++;
      end
      check("abort_no_done", seen_done, 0);
    end
    $display("abort mid-run complete");

    // Randomized traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      op_valid  = ($urandom_range(0, 1) == 1);
      op        = 2'($urandom_range(0, 3));
      ch        = 2'($urandom_range(0, NCH - 1));
      case ($urandom_range(0, 3))
        0:       din = 16'h0000;
        1:       din = 16'hFFFF;
        default: din = 16'($urandom);
      endcase
      blk_start = ($urandom_range(0, 9) == 0);
      blk_dir   = ($urandom_range(0, 1) == 1);
      blk_len   = 8'($urandom_range(0, 5));
      stall     = ($urandom_range(0, 3) == 0);
      #1;
      check_model("rand");
      tick();
    end
    op_valid = 0; blk_start = 0; stall = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
